// File: rtl/sram_ctrl.sv
// Multi-cycle controller that splits 32-bit loads/stores into two 16-bit SRAM accesses.
// Optional stall statistic enabled by defining SRAM_CTRL_STATS_EN.
module sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 4,
    parameter int unsigned BASE_ADDR   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

    localparam logic [3:0] LastCnt = 4'(WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] off;
    logic        last;
    logic        unused_off;

    assign off        = addr_q - BASE_ADDR;
    assign last       = (cnt_q == LastCnt);
    assign unused_off = ^{off[31:19], off[1:0]};
    assign rdata      = rdata_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        is_wr_d     = is_wr_q;
        rdata_d     = rdata_q;
        ready       = 1'b1;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (rd_en || wr_en) begin
                    ready   = 1'b0;
                    state_d = StLow;
                    cnt_d   = '0;
                    addr_d  = address;
                    wdata_d = wdata;
                    is_wr_d = wr_en;
                end
            end
            StLow: begin
                ready     = 1'b0;
                sram_addr = {off[18:2], 1'b0};
                if (is_wr_q) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata_q[15:0];
                end
                if (last) begin
                    state_d = StHigh;
                    cnt_d   = '0;
                    if (!is_wr_q) rdata_d[15:0] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StHigh: begin
                ready     = 1'b0;
                sram_addr = {off[18:2], 1'b1};
                if (is_wr_q) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata_q[31:16];
                end
                if (last) begin
                    state_d = StDone;
                    cnt_d   = '0;
                    if (!is_wr_q) rdata_d[31:16] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDone: begin
                // Always return to idle so a held request costs one ready cycle
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            is_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            is_wr_q <= is_wr_d;
        end
    end

`ifdef SRAM_CTRL_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!ready && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter: WAIT_CYCLES, default 4, SRAM cycles per 16-bit half-access; legal range 1..15.
REQ-002 Parameter: BASE_ADDR, default 1024, byte address that maps to SRAM word 0.
REQ-003 Port: clk  in  1  sole clock, rising edge.
REQ-004 Port: rst  in  1  synchronous, active-high reset.
REQ-005 Ports, from the MEM stage:
  - rd_en  in  1  load request.
  - wr_en  in  1  store request.
  - address  in  32  byte address, word-aligned.
  - wdata  in  32  store data.
REQ-006 Ports, to the MEM stage and pipeline:
  - rdata  out  32  load result.
  - ready  out  1  high = MEM stage may advance; low = freeze all pipeline registers including MEM/WB.
REQ-007 Ports, to the SRAM:
  - sram_addr  out  18  SRAM 16-bit word address.
  - sram_dq_out  out  16  write data.
  - sram_dq_in  in  16  read data.
  - sram_dq_oe  out  1  tri-state enable.
  - sram_we_n  out  1  active-low write strobe.
REQ-008 Port: stall_cnt  out  32  stall-cycle statistic (see Configuration).

Function
REQ-009 The FSM SHALL have exactly four states: IDLE, LOW, HIGH, DONE.
REQ-010 IDLE with rd_en or wr_en high -> LOW. At that edge the block SHALL latch address, wdata and op (write if wr_en, else read).
REQ-011 If rd_en and wr_en are both high, the block SHALL perform a write only.
REQ-012 LOW and HIGH SHALL each last exactly WAIT_CYCLES cycles, timed by a 4-bit counter cleared on entry; LOW -> HIGH -> DONE.
REQ-013 DONE SHALL last exactly one cycle -> IDLE, even if a request is still present.
REQ-014 Off = (latched address - BASE_ADDR). sram_addr SHALL be {off[18:2],0} in LOW and {off[18:2],1} in HIGH, and 0 in IDLE and DONE.
REQ-015 For a write:
  - sram_we_n = 0 and sram_dq_oe = 1 throughout LOW and HIGH.
  - sram_dq_out = wdata[15:0] in LOW and wdata[31:16] in HIGH.
  - Otherwise sram_we_n = 1, sram_dq_oe = 0 and sram_dq_out = 0.
REQ-016 For a read:
  - rdata[15:0] SHALL be captured from sram_dq_in on the last LOW cycle.
  - rdata[31:16] SHALL be captured on the last HIGH cycle.
  - rdata SHALL hold until the next read captures; writes SHALL NOT change rdata.
REQ-017 ready SHALL be combinational: 0 in IDLE when rd_en|wr_en, 0 in LOW and HIGH, 1 otherwise.
REQ-018 Latency SHALL be a request in cycle 0 with ready low in cycles 0..2*WAIT_CYCLES and high in cycle 2*WAIT_CYCLES+1 (DONE).
REQ-019 Requests deasserting or changing during LOW/HIGH SHALL NOT affect the access in progress.
REQ-020 A request present in the cycle after DONE SHALL start a new access.

Reset
REQ-021 With rst high at a clk edge, on that edge: state = IDLE, counter = 0, rdata = 0, stall_cnt = 0, latched registers = 0.
REQ-022 Reset during LOW/HIGH SHALL abort the access and return sram_we_n = 1, sram_dq_oe = 0 in the following cycle; no partial rdata update.
REQ-023 rst SHALL have priority over every other input.

Configuration
REQ-024 Macro SRAM_CTRL_STATS_EN defined:
  - stall_cnt SHALL increment by 1 on each clk edge where ready = 0 and rst = 0.
  - stall_cnt SHALL saturate at 32'hFFFFFFFF.
REQ-025 Macro SRAM_CTRL_STATS_EN undefined: stall_cnt SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-026 The bench SHALL cover these scenarios, WAIT_CYCLES=4:
  - V1: write wr_en=1, address=1028, wdata=32'hDEADBEEF -> sram_addr=2, dq_out=16'hBEEF, we_n=0 for 4 cycles; then sram_addr=3, dq_out=16'hDEAD for 4 cycles; ready high in cycle 9.
  - V2: read rd_en=1, address=1028, SRAM model returns words 2/3 = BEEF/DEAD -> rdata=32'hDEADBEEF in cycle 9, ready low cycles 0..8.
  - V3: rd_en=wr_en=1 -> write sequence only, rdata unchanged.
  - V4: rst asserted in cycle 3 of a write -> next cycle IDLE, we_n=1, oe=0, ready=1, rdata unchanged from reset value 0.
  - V5: rd_en held high across two back-to-back reads -> DONE in cycles 9 and 19, ready high only in those cycles; with SRAM_CTRL_STATS_EN, stall_cnt=18 afterwards (0 without).
